// File: rtl/symtab_seq.sv
// Runtime-loadable symbol table: registered index->char lookup plus a
// multi-cycle char->index search over LANES entries per cycle.
// Optional feature macro: SYMTAB_DEFAULT_ALPHA_EN (reset preloads "A".."Z").
module symtab_seq #(
    parameter int CHAR_W = 8,
    parameter int IDX_W  = 5,
    parameter int DEPTH  = 32,
    parameter int LANES  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [CHAR_W-1:0] wr_ch,
    input  logic              clr,
    input  logic              fwd_req,
    input  logic [IDX_W-1:0]  fwd_idx,
    output logic              fwd_vld,
    output logic [CHAR_W-1:0] fwd_ch,
    output logic              fwd_hit,
    input  logic              rev_req,
    input  logic [CHAR_W-1:0] rev_ch,
    output logic              rev_rdy,
    output logic              rev_done,
    output logic              rev_found,
    output logic [IDX_W-1:0]  rev_idx
);

    localparam int NGRP  = DEPTH / LANES;
    localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

    typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

    logic [CHAR_W-1:0] data_r [DEPTH];
    logic [DEPTH-1:0]  valid_r;

    state_t            state_r, state_nxt_s;
    logic [GRP_W-1:0]  grp_r;
    logic [CHAR_W-1:0] key_r;

    logic              any_hit_s;
    logic [IDX_W-1:0]  hit_idx_s;
    logic              last_grp_s;

    logic              fwd_hit_s;
    logic [CHAR_W-1:0] fwd_ch_s;
    logic              fwd_vld_r, fwd_hit_r;
    logic [CHAR_W-1:0] fwd_ch_r;

    logic              rev_rdy_s, rev_done_s, rev_found_s;
    logic [IDX_W-1:0]  rev_idx_s;
    logic              rev_done_r, rev_found_r;
    logic [IDX_W-1:0]  rev_idx_r;

    // Table storage: clr beats wr_en; clr leaves data untouched
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef SYMTAB_DEFAULT_ALPHA_EN
                data_r[i]  <= (i < 26) ? CHAR_W'(8'd65 + i) : '0;
                valid_r[i] <= (i < 26) ? 1'b1 : 1'b0;
`else
                data_r[i]  <= '0;
                valid_r[i] <= 1'b0;
`endif
            end
        end else if (clr) begin
            valid_r <= '0;
        end else if (wr_en && ({1'b0, wr_idx} < DEPTH_L)) begin
            data_r[wr_idx]  <= wr_ch;
            valid_r[wr_idx] <= 1'b1;
        end
    end

    // Forward read of pre-edge contents
    always_comb begin
        fwd_hit_s = 1'b0;
        fwd_ch_s  = '0;
        if (({1'b0, fwd_idx} < DEPTH_L) && valid_r[fwd_idx]) begin
            fwd_hit_s = 1'b1;
            fwd_ch_s  = data_r[fwd_idx];
        end else begin
            fwd_hit_s = 1'b0;
            fwd_ch_s  = '0;
        end
    end

    // Forward result registers; ch/hit hold between requests
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_vld_r <= 1'b0;
            fwd_hit_r <= 1'b0;
            fwd_ch_r  <= '0;
        end else begin
            fwd_vld_r <= fwd_req;
            if (fwd_req) begin
                fwd_hit_r <= fwd_hit_s;
                fwd_ch_r  <= fwd_ch_s;
            end
        end
    end

    // Compare the current group; scanning lanes high-to-low leaves the lowest hit
    always_comb begin
        logic [IDX_W-1:0] e_v;
        any_hit_s = 1'b0;
        hit_idx_s = '0;
        e_v       = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            e_v = IDX_W'(int'(grp_r) * LANES + l);
            if (valid_r[e_v] && (data_r[e_v] == key_r)) begin
                any_hit_s = 1'b1;
                hit_idx_s = e_v;
            end else begin
                any_hit_s = any_hit_s;
            end
        end
        last_grp_s = (grp_r == GRP_W'(NGRP - 1));
    end

    // Reverse FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Reverse FSM next state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (rev_req) state_nxt_s = SCAN;
                else         state_nxt_s = IDLE;
            end
            SCAN: begin
                if (any_hit_s || last_grp_s) state_nxt_s = IDLE;
                else                         state_nxt_s = SCAN;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Reverse FSM outputs and next result values
    always_comb begin
        rev_rdy_s   = (state_r == IDLE);
        rev_done_s  = 1'b0;
        rev_found_s = rev_found_r;
        rev_idx_s   = rev_idx_r;
        if ((state_r == SCAN) && (any_hit_s || last_grp_s)) begin
            rev_done_s  = 1'b1;
            rev_found_s = any_hit_s;
            rev_idx_s   = any_hit_s ? hit_idx_s : '0;
        end else begin
            rev_done_s  = 1'b0;
        end
    end

    // Search datapath: key capture, group counter, result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grp_r       <= '0;
            key_r       <= '0;
            rev_done_r  <= 1'b0;
            rev_found_r <= 1'b0;
            rev_idx_r   <= '0;
        end else begin
            rev_done_r  <= rev_done_s;
            rev_found_r <= rev_found_s;
            rev_idx_r   <= rev_idx_s;
            if ((state_r == IDLE) && rev_req) begin
                key_r <= rev_ch;
                grp_r <= '0;
            end else if (state_r == SCAN) begin
                grp_r <= grp_r + GRP_W'(1);
            end
        end
    end

    assign fwd_vld   = fwd_vld_r;
    assign fwd_ch    = fwd_ch_r;
    assign fwd_hit   = fwd_hit_r;
    assign rev_rdy   = rev_rdy_s;
    assign rev_done  = rev_done_r;
    assign rev_found = rev_found_r;
    assign rev_idx   = rev_idx_r;

endmodule

// File: tb/tb_symtab_seq.sv
// Directed self-checking bench for symtab_seq; works with or without
// SYMTAB_DEFAULT_ALPHA_EN (the alphabet is written explicitly when absent).
module tb_symtab_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [4:0] wr_idx = 5'd0;
    logic [7:0] wr_ch = 8'd0;
    logic       clr = 1'b0;
    logic       fwd_req = 1'b0;
    logic [4:0] fwd_idx = 5'd0;
    logic       fwd_vld;
    logic [7:0] fwd_ch;
    logic       fwd_hit;
    logic       rev_req = 1'b0;
    logic [7:0] rev_ch = 8'd0;
    logic       rev_rdy;
    logic       rev_done;
    logic       rev_found;
    logic [4:0] rev_idx;

    int vectors = 0;
    int errors  = 0;

    symtab_seq dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_ch(wr_ch), .clr(clr),
        .fwd_req(fwd_req), .fwd_idx(fwd_idx),
        .fwd_vld(fwd_vld), .fwd_ch(fwd_ch), .fwd_hit(fwd_hit),
        .rev_req(rev_req), .rev_ch(rev_ch), .rev_rdy(rev_rdy),
        .rev_done(rev_done), .rev_found(rev_found), .rev_idx(rev_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic load_alpha();
`ifndef SYMTAB_DEFAULT_ALPHA_EN
        for (int i = 0; i < 26; i++) begin
            wr_en = 1'b1; wr_idx = 5'(i); wr_ch = 8'(8'h41 + i);
            tick();
        end
        wr_en = 1'b0;
`endif
    endtask

    task automatic fwd_read(input logic [4:0] idx);
        fwd_req = 1'b1; fwd_idx = idx;
        tick();
        fwd_req = 1'b0;
    endtask

    // Launches a search, optionally writing or re-requesting during scan cycle n
    task automatic run_search(input logic [7:0] ch, input int wr_at,
                              input logic [4:0] w_idx, input logic [7:0] w_ch,
                              input int req_at, output logic f,
                              output logic [4:0] ix, output int cyc);
        cyc = 99; f = 1'b0; ix = 5'd0;
        rev_ch = ch; rev_req = 1'b1;
        tick();
        rev_req = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (n == wr_at) begin
                wr_en = 1'b1; wr_idx = w_idx; wr_ch = w_ch;
            end
            if (n == req_at) begin
                rev_req = 1'b1; rev_ch = 8'h41;
            end
            tick();
            wr_en = 1'b0; rev_req = 1'b0;
            if (rev_done) begin
                cyc = n; f = rev_found; ix = rev_idx;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({fwd_vld, fwd_ch, fwd_hit} !== 10'd0) begin
            errors++; $display("FAIL reset_fwd got vld=%b ch=%h hit=%b want 0/00/0", fwd_vld, fwd_ch, fwd_hit);
        end
        vectors++;
        if ({rev_done, rev_found, rev_idx, rev_rdy} !== 8'b0000_0001) begin
            errors++; $display("FAIL reset_rev got done=%b found=%b idx=%0d rdy=%b want 0/0/0/1", rev_done, rev_found, rev_idx, rev_rdy);
        end
        fwd_read(5'd0);
        vectors++;
`ifdef SYMTAB_DEFAULT_ALPHA_EN
        if (fwd_hit !== 1'b1 || fwd_ch !== 8'h41) begin
            errors++; $display("FAIL reset_table got hit=%b ch=%h want 1/41", fwd_hit, fwd_ch);
        end
`else
        if (fwd_hit !== 1'b0 || fwd_ch !== 8'h00) begin
            errors++; $display("FAIL reset_table got hit=%b ch=%h want 0/00", fwd_hit, fwd_ch);
        end
`endif
        load_alpha();
    endtask

    task automatic test_forward();
        logic [4:0] idx_t [3] = '{5'd0, 5'd31, 5'd25};
        logic [7:0] ch_t  [3] = '{8'h41, 8'h00, 8'h5A};
        logic       hit_t [3] = '{1'b1, 1'b0, 1'b1};
        fwd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fwd_idx = idx_t[i];
            tick();
            vectors++;
            if (fwd_vld !== 1'b1 || fwd_ch !== ch_t[i] || fwd_hit !== hit_t[i]) begin
                errors++; $display("FAIL fwd_idx%0d got vld=%b ch=%h hit=%b want 1/%h/%b", idx_t[i], fwd_vld, fwd_ch, fwd_hit, ch_t[i], hit_t[i]);
            end
        end
        fwd_req = 1'b0;
        fwd_idx = 5'd1;
        tick();
        vectors++;
        if (fwd_vld !== 1'b0 || fwd_ch !== 8'h5A || fwd_hit !== 1'b1) begin
            errors++; $display("FAIL fwd_hold got vld=%b ch=%h hit=%b want 0/5a/1", fwd_vld, fwd_ch, fwd_hit);
        end
    endtask

    task automatic test_reverse();
        logic [7:0] ch_t  [3] = '{8'h41, 8'h5A, 8'h40};
        logic       f_t   [3] = '{1'b1, 1'b1, 1'b0};
        logic [4:0] ix_t  [3] = '{5'd0, 5'd25, 5'd0};
        int         cyc_t [3] = '{1, 7, 8};
        logic f; logic [4:0] ix; int cyc;
        for (int i = 0; i < 3; i++) begin
            run_search(ch_t[i], 0, 5'd0, 8'd0, 0, f, ix, cyc);
            vectors++;
            if (f !== f_t[i] || ix !== ix_t[i] || cyc != cyc_t[i]) begin
                errors++; $display("FAIL rev_%h got found=%b idx=%0d cyc=%0d want %b/%0d/%0d", ch_t[i], f, ix, cyc, f_t[i], ix_t[i], cyc_t[i]);
            end
        end
    endtask

    task automatic test_write();
        logic f; logic [4:0] ix; int cyc;
        wr_en = 1'b1; wr_idx = 5'd27; wr_ch = 8'h23;
        tick();
        wr_idx = 5'd30; wr_ch = 8'h50;
        tick();
        wr_en = 1'b0;
        run_search(8'h23, 0, 5'd0, 8'd0, 0, f, ix, cyc);
        vectors++;
        if (f !== 1'b1 || ix !== 5'd27 || cyc != 7) begin
            errors++; $display("FAIL write_hash got found=%b idx=%0d cyc=%0d want 1/27/7", f, ix, cyc);
        end
        run_search(8'h50, 0, 5'd0, 8'd0, 0, f, ix, cyc);
        vectors++;
        if (f !== 1'b1 || ix !== 5'd15 || cyc != 4) begin
            errors++; $display("FAIL dup_lowest got found=%b idx=%0d cyc=%0d want 1/15/4", f, ix, cyc);
        end
        // Read and write the same index in one cycle: old data comes back
        wr_en = 1'b1; wr_idx = 5'd2; wr_ch = 8'h78;
        fwd_read(5'd2);
        wr_en = 1'b0;
        vectors++;
        if (fwd_ch !== 8'h43 || fwd_hit !== 1'b1) begin
            errors++; $display("FAIL rd_wr_same got ch=%h hit=%b want 43/1", fwd_ch, fwd_hit);
        end
        fwd_read(5'd2);
        vectors++;
        if (fwd_ch !== 8'h78) begin
            errors++; $display("FAIL rd_after_wr got ch=%h want 78", fwd_ch);
        end
        wr_en = 1'b1; wr_ch = 8'h43;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_clr();
        logic f; logic [4:0] ix; int cyc;
        clr = 1'b1; wr_en = 1'b1; wr_idx = 5'd5; wr_ch = 8'h46;
        tick();
        clr = 1'b0; wr_en = 1'b0;
        run_search(8'h41, 0, 5'd0, 8'd0, 0, f, ix, cyc);
        vectors++;
        if (f !== 1'b0 || ix !== 5'd0 || cyc != 8) begin
            errors++; $display("FAIL clr_search got found=%b idx=%0d cyc=%0d want 0/0/8", f, ix, cyc);
        end
        fwd_read(5'd0);
        vectors++;
        if (fwd_hit !== 1'b0 || fwd_ch !== 8'h00) begin
            errors++; $display("FAIL clr_fwd got hit=%b ch=%h want 0/00", fwd_hit, fwd_ch);
        end
        fwd_read(5'd5);
        vectors++;
        if (fwd_hit !== 1'b0) begin
            errors++; $display("FAIL clr_over_wr got hit=%b want 0", fwd_hit);
        end
    endtask

    task automatic test_reset_midscan();
        logic f; logic [4:0] ix; int cyc;
        int seen;
        do_reset();
        load_alpha();
        run_search(8'h5A, 0, 5'd0, 8'd0, 0, f, ix, cyc);
        rev_ch = 8'h40; rev_req = 1'b1;
        tick();
        rev_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if (rev_rdy !== 1'b1 || rev_done !== 1'b0 || rev_found !== 1'b0 || rev_idx !== 5'd0) begin
            errors++; $display("FAIL midscan_rst got rdy=%b done=%b found=%b idx=%0d want 1/0/0/0", rev_rdy, rev_done, rev_found, rev_idx);
        end
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (rev_done === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0 || rev_rdy !== 1'b1) begin
            errors++; $display("FAIL midscan_abort got done_pulses=%0d rdy=%b want 0/1", seen, rev_rdy);
        end
        load_alpha();
    endtask

    task automatic test_scan_write();
        logic f; logic [4:0] ix; int cyc;
        run_search(8'h26, 3, 5'd31, 8'h26, 0, f, ix, cyc);
        vectors++;
        if (f !== 1'b1 || ix !== 5'd31 || cyc != 8) begin
            errors++; $display("FAIL scan_write got found=%b idx=%0d cyc=%0d want 1/31/8", f, ix, cyc);
        end
    endtask

    task automatic test_back_to_back();
        logic f; logic [4:0] ix; int cyc;
        fwd_req = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            fwd_idx = 5'(i);
            tick();
            vectors++;
            if (fwd_vld !== 1'b1 || fwd_ch !== 8'(8'h41 + i)) begin
                errors++; $display("FAIL b2b_fwd%0d got vld=%b ch=%h want 1/%h", i, fwd_vld, fwd_ch, 8'(8'h41 + i));
            end
        end
        fwd_req = 1'b0;
        rev_ch = 8'h41; rev_req = 1'b1;
        tick();
        rev_req = 1'b0;
        tick();
        vectors++;
        if (rev_done !== 1'b1 || rev_rdy !== 1'b1 || rev_idx !== 5'd0) begin
            errors++; $display("FAIL b2b_rev1 got done=%b rdy=%b idx=%0d want 1/1/0", rev_done, rev_rdy, rev_idx);
        end
        rev_ch = 8'h42; rev_req = 1'b1;
        tick();
        rev_req = 1'b0;
        tick();
        vectors++;
        if (rev_done !== 1'b1 || rev_found !== 1'b1 || rev_idx !== 5'd1) begin
            errors++; $display("FAIL b2b_rev2 got done=%b found=%b idx=%0d want 1/1/1", rev_done, rev_found, rev_idx);
        end
        run_search(8'h40, 0, 5'd0, 8'd0, 2, f, ix, cyc);
        vectors++;
        if (f !== 1'b0 || ix !== 5'd0 || cyc != 8) begin
            errors++; $display("FAIL busy_req_ignored got found=%b idx=%0d cyc=%0d want 0/0/8", f, ix, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_write();
        test_clr();
        test_reset_midscan();
        test_scan_write();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
